// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

    localparam int WIDTH = 4;
    localparam int ITER  = 4;

    localparam logic [WIDTH-1:0] DBZ_QUOTIENT = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/restoring_divider_if.sv
// Host-side start/ready/done handshake and operand/result bus of the divider.
interface restoring_divider_if;
    import divider_pkg::*;

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/subtractor.sv
// Combinational 4-bit subtractor datapath block: d = a - b (modulo 16).
module subtractor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] d
);

    assign d = a - b;

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one shared subtractor, one quotient bit
// per clock, start/ready/done handshake with registered results.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = divider_pkg::WIDTH,
    parameter int ITER  = divider_pkg::ITER
) (
    input  logic                clk,
    input  logic                rst_n,
    restoring_divider_if.slave  bus
);

    localparam int CNT_W = $clog2(ITER);

    state_e             state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;

    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   diff;
    logic               ge;

    // Shift the next dividend bit into the partial remainder before comparing.
    assign trial = {a_q[WIDTH-1:0], q_q[WIDTH-1]};

    subtractor u_sub (
        .a (trial[WIDTH-1:0]),
        .b (d_q),
        .d (diff)
    );

    // With trial[WIDTH] set the true difference is below D, so the 4-bit d is exact.
    assign ge = trial[WIDTH] | (trial[WIDTH-1:0] >= d_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ready_d = ready_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && ready_q) begin
                    if (bus.divisor == '0) begin
                        quot_d = DBZ_QUOTIENT;
                        rem_d  = bus.dividend;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        a_d     = '0;
                        q_d     = bus.dividend;
                        d_d     = bus.divisor;
                        cnt_d   = CNT_W'(ITER - 1);
                        dbz_d   = 1'b0;
                        ready_d = 1'b0;
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (ge) begin
                    a_d = {1'b0, diff};
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    a_d = trial;
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    quot_d  = q_d;
                    rem_d   = a_d[WIDTH-1:0];
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and exhaustive checks of restoring_divider results, latency and handshake.
module tb_restoring_divider;
    import divider_pkg::*;

    localparam int TIMEOUT = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    restoring_divider_if dif ();

    restoring_divider #(.WIDTH(4), .ITER(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands for exactly one edge; the caller ensures ready is high.
    task automatic accept(input logic [3:0] dd, input logic [3:0] dv);
        dif.start    = 1'b1;
        dif.dividend = dd;
        dif.divisor  = dv;
        step();
        dif.start    = 1'b0;
    endtask

    // Counts edges after the acceptance edge until done is seen.
    task automatic wait_done(output int edges);
        edges = 0;
        while (dif.done !== 1'b1 && edges < TIMEOUT) begin
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        rst_n        = 1'b0;
        step();
        step();
        checks++; if (dif.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", dif.ready); end
        checks++; if (dif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", dif.done); end
        checks++; if (dif.quotient !== 4'd0) begin errors++; $display("FAIL reset_quot: got %0d want 0", dif.quotient); end
        checks++; if (dif.remainder !== 4'd0) begin errors++; $display("FAIL reset_rem: got %0d want 0", dif.remainder); end
        checks++; if (dif.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", dif.div_by_zero); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int e;
        accept(4'd13, 4'd3);
        checks++; if (dif.ready !== 1'b0) begin errors++; $display("FAIL basic_ready_low: got %b want 0", dif.ready); end
        wait_done(e);
        $display("div 13/3 -> q=%0d r=%0d dbz=%b edges=%0d", dif.quotient, dif.remainder, dif.div_by_zero, e);
        checks++; if (e !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", e); end
        checks++; if (dif.quotient !== 4'd4) begin errors++; $display("FAIL basic_quot: got %0d want 4", dif.quotient); end
        checks++; if (dif.remainder !== 4'd1) begin errors++; $display("FAIL basic_rem: got %0d want 1", dif.remainder); end
        checks++; if (dif.div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b want 0", dif.div_by_zero); end
        checks++; if (dif.ready !== 1'b1) begin errors++; $display("FAIL basic_ready_done: got %b want 1", dif.ready); end
        step();
        checks++; if (dif.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", dif.done); end
    endtask

    task automatic test_vectors();
        logic [3:0] vdd [4] = '{4'd15, 4'd8, 4'd15, 4'd0};
        logic [3:0] vdv [4] = '{4'd1,  4'd9, 4'd15, 4'd5};
        logic [3:0] vq  [4] = '{4'd15, 4'd0, 4'd1,  4'd0};
        logic [3:0] vr  [4] = '{4'd0,  4'd8, 4'd0,  4'd0};
        int e;
        for (int i = 0; i < 4; i++) begin
            accept(vdd[i], vdv[i]);
            wait_done(e);
            $display("div %0d/%0d -> q=%0d r=%0d edges=%0d", vdd[i], vdv[i], dif.quotient, dif.remainder, e);
            checks++; if (e !== 4) begin errors++; $display("FAIL vec%0d_latency: got %0d want 4", i, e); end
            checks++; if (dif.quotient !== vq[i]) begin errors++; $display("FAIL vec%0d_quot: got %0d want %0d", i, dif.quotient, vq[i]); end
            checks++; if (dif.remainder !== vr[i]) begin errors++; $display("FAIL vec%0d_rem: got %0d want %0d", i, dif.remainder, vr[i]); end
            step();
        end
    endtask

    task automatic test_div_by_zero();
        accept(4'd7, 4'd0);
        $display("div 7/0 -> q=%0d r=%0d dbz=%b done=%b", dif.quotient, dif.remainder, dif.div_by_zero, dif.done);
        checks++; if (dif.done !== 1'b1) begin errors++; $display("FAIL dbz_done: got %b want 1", dif.done); end
        checks++; if (dif.ready !== 1'b1) begin errors++; $display("FAIL dbz_ready: got %b want 1", dif.ready); end
        checks++; if (dif.quotient !== 4'hF) begin errors++; $display("FAIL dbz_quot: got %0h want f", dif.quotient); end
        checks++; if (dif.remainder !== 4'd7) begin errors++; $display("FAIL dbz_rem: got %0d want 7", dif.remainder); end
        checks++; if (dif.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b want 1", dif.div_by_zero); end
        step();
        checks++; if (dif.done !== 1'b0) begin errors++; $display("FAIL dbz_done_pulse: got %b want 0", dif.done); end
        checks++; if (dif.quotient !== 4'hF) begin errors++; $display("FAIL dbz_hold: got %0h want f", dif.quotient); end
    endtask

    task automatic test_back_to_back();
        int e;
        accept(4'd13, 4'd3);
        step();
        dif.start    = 1'b1;
        dif.dividend = 4'd9;
        dif.divisor  = 4'd2;
        step();
        dif.start    = 1'b0;
        wait_done(e);
        $display("div 13/3 (start re-pulsed) -> q=%0d r=%0d edges=%0d", dif.quotient, dif.remainder, e);
        checks++; if (e !== 2) begin errors++; $display("FAIL ignore_latency: got %0d want 2", e); end
        checks++; if (dif.quotient !== 4'd4) begin errors++; $display("FAIL ignore_quot: got %0d want 4", dif.quotient); end
        checks++; if (dif.remainder !== 4'd1) begin errors++; $display("FAIL ignore_rem: got %0d want 1", dif.remainder); end
        accept(4'd9, 4'd2);
        checks++; if (dif.ready !== 1'b0) begin errors++; $display("FAIL b2b_accepted: ready got %b want 0", dif.ready); end
        wait_done(e);
        $display("div 9/2 -> q=%0d r=%0d edges=%0d", dif.quotient, dif.remainder, e);
        checks++; if (e !== 4) begin errors++; $display("FAIL b2b_latency: got %0d want 4", e); end
        checks++; if (dif.quotient !== 4'd4) begin errors++; $display("FAIL b2b_quot: got %0d want 4", dif.quotient); end
        checks++; if (dif.remainder !== 4'd1) begin errors++; $display("FAIL b2b_rem: got %0d want 1", dif.remainder); end
        step();
    endtask

    task automatic test_reset_mid_run();
        int  e;
        logic seen_done;
        accept(4'd11, 4'd4);
        step();
        step();
        checks++; if (dif.quotient !== 4'd4) begin errors++; $display("FAIL midrun_prior_result: got %0d want 4", dif.quotient); end
        rst_n = 1'b0;
        #1;
        checks++; if (dif.quotient !== 4'd0) begin errors++; $display("FAIL abort_quot: got %0d want 0", dif.quotient); end
        checks++; if (dif.remainder !== 4'd0) begin errors++; $display("FAIL abort_rem: got %0d want 0", dif.remainder); end
        checks++; if (dif.ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", dif.ready); end
        checks++; if (dif.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", dif.done); end
        step();
        step();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (dif.done !== 1'b0) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", seen_done); end
        accept(4'd11, 4'd4);
        wait_done(e);
        $display("div 11/4 after abort -> q=%0d r=%0d edges=%0d", dif.quotient, dif.remainder, e);
        checks++; if (e !== 4) begin errors++; $display("FAIL rerun_latency: got %0d want 4", e); end
        checks++; if (dif.quotient !== 4'd2) begin errors++; $display("FAIL rerun_quot: got %0d want 2", dif.quotient); end
        checks++; if (dif.remainder !== 4'd3) begin errors++; $display("FAIL rerun_rem: got %0d want 3", dif.remainder); end
        step();
    endtask

    task automatic test_sweep();
        int e;
        int exp_e;
        logic [3:0] exp_q;
        logic [3:0] exp_r;
        logic       exp_z;
        for (int dd = 0; dd < 16; dd++) begin
            for (int dv = 0; dv < 16; dv++) begin
                exp_z = (dv == 0);
                exp_e = exp_z ? 0 : 4;
                exp_q = exp_z ? 4'hF : 4'(dd / dv);
                exp_r = exp_z ? 4'(dd) : 4'(dd % dv);
                // Issued in the previous done cycle, so this also exercises back-to-back acceptance.
                accept(4'(dd), 4'(dv));
                wait_done(e);
                $display("sweep %0d/%0d -> q=%0d r=%0d dbz=%b edges=%0d", dd, dv, dif.quotient, dif.remainder, dif.div_by_zero, e);
                checks++;
                if (e !== exp_e || dif.quotient !== exp_q || dif.remainder !== exp_r || dif.div_by_zero !== exp_z) begin
                    errors++;
                    $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d dbz=%b edges=%0d want q=%0d r=%0d dbz=%b edges=%0d",
                             dd, dv, dif.quotient, dif.remainder, dif.div_by_zero, e, exp_q, exp_r, exp_z, exp_e);
                end
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
